// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: protocol widths, ACK levels and the FSM state type.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: 2-FF synchronizer, FILT_LEN-sample glitch filter, registered rise/fall strobes.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) filt_d = sync_q[1];
      else                               cnt_d  = cnt_q + 1'b1;
    end
    rise_d = ~filt_q &  filt_d;
    fall_d =  filt_q & ~filt_d;
  end

  // The idle bus level is high, so the line resets as released.
  // NOTE: non-blocking assignments here so all flops sample pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an 8-bit register file: pointer byte, then auto-incrementing data writes or reads.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TGT_ADDR = 7'h50,
  parameter int                NUM_REGS = 16,
  parameter int                FILT_LEN = 3
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              SCL_I,
  input  logic              SDA_I,
  output logic              SDA_OE,
  output logic              WR_STB,
  output logic [BYTE_W-1:0] WR_ADDR,
  output logic [BYTE_W-1:0] WR_DATA,
  output logic              BUSY
);

  localparam int PTR_W = $clog2(NUM_REGS);

  logic scl_filt, scl_rise, scl_fall;
  logic sda_filt, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(PCLK), .rst_n(PRESETN), .line_i(SCL_I),
    .filt_o(scl_filt), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(PCLK), .rst_n(PRESETN), .line_i(SDA_I),
    .filt_o(sda_filt), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start = sda_fall & scl_filt;
  assign stop  = sda_rise & scl_filt;

  i2c_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc;
  logic              rw_q, rw_d;
  logic              oe_q, oe_d;
  logic              wr_stb_q, wr_stb_d;
  logic [BYTE_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] regs_q [NUM_REGS];
  logic [BYTE_W-1:0] regs_d [NUM_REGS];
  logic [BYTE_W-1:0] rx_byte;

  assign ptr_inc = ptr_q + 1'b1;
  assign rx_byte = {shift_q[BYTE_W-2:0], sda_filt};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    regs_d    = regs_q;

    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (state_q == WDATA && cnt_q == 4'd7) begin
              regs_d[ptr_q] = rx_byte;
              wr_stb_d      = 1'b1;
              wr_addr_d     = BYTE_W'(ptr_q);
              wr_data_d     = rx_byte;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            // Falling edge after the 8th bit: decide whether to drive ACK for the 9th clock.
            cnt_d = '0;
            oe_d  = 1'b1;
            case (state_q)
              ADDR: begin
                if (shift_q[BYTE_W-1:1] == TGT_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = shift_q[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                  oe_d    = 1'b0;
                end
              end
              PTR: begin
                ptr_d   = shift_q[PTR_W-1:0];
                state_d = PTR_ACK;
              end
              default: begin
                ptr_d   = ptr_inc;
                state_d = WDATA_ACK;
              end
            endcase
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d = RDATA;
              shift_d = regs_q[ptr_q];
              oe_d    = ~regs_q[ptr_q][BYTE_W-1];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            state_d = WDATA;
            oe_d    = 1'b0;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RDATA_ACK;
              cnt_d   = '0;
              oe_d    = 1'b0;
            end else begin
              oe_d = ~shift_q[BYTE_W-1];
            end
          end
        end
        RDATA_ACK: begin
          // The master's ACK bit lands in shift_q[0] on the 9th rising edge.
          if (scl_rise) begin
            shift_d = rx_byte;
          end else if (scl_fall) begin
            if (shift_q[0] == I2C_ACK) begin
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
              oe_d    = ~regs_q[ptr_inc][BYTE_W-1];
              state_d = RDATA;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      // NOTE: the register file is reset because its contents are readable straight after reset.
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      regs_q    <= regs_d;
    end
  end

  assign SDA_OE  = oe_q;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign BUSY    = busy_q;

endmodule
